// File: rtl/dac_feed_ctrl.sv
// dac_feed_ctrl
// Feeds a DAC data register from two sample requesters at a programmable
// sample rate. The arbiter is either fixed priority (requester 0 first) or
// round-robin. A sample slot in RUN that has no valid requester is counted
// in a saturating underflow counter.
//
// Build option: define DAC_FEED_OFFSET_BIN_EN to convert two's complement
// samples to offset binary (MSB inverted) on their way to the DAC.
module dac_feed_ctrl #(
    parameter int DATA_W = 14,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [DIV_W-1:0]  i_rate_div,
    input  logic              i_prio_fixed,
    input  logic              i_clr_underflow,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_dac_strobe,
    output logic [1:0]        o_grant,
    output logic [15:0]       o_underflow_cnt,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

`ifdef DAC_FEED_OFFSET_BIN_EN
    localparam logic [DATA_W-1:0] DAC_RST_VAL = {1'b1, {(DATA_W-1){1'b0}}};
`else
    localparam logic [DATA_W-1:0] DAC_RST_VAL = '0;
`endif

    // Maps an accepted sample to the DAC code.
    function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
`ifdef DAC_FEED_OFFSET_BIN_EN
        return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
        return s;
`endif
    endfunction

    state_t            state, state_nxt;
    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  rate_q;
    logic              tick;
    logic              slot;
    logic              rr_last1;
    logic              prefer1;
    logic              gnt1;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic              underflow;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Sample-rate divider; the period is reloaded only at wrap (and while idle).
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            div_cnt <= '0;
            rate_q  <= '0;
        end else if (state == ST_IDLE || tick) begin
            div_cnt <= '0;
            rate_q  <= i_rate_div;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (state != ST_IDLE) && (div_cnt == rate_q);

    // A usable slot also needs i_enable, so ready drops the moment enable falls.
    assign slot = tick && i_enable;

    // Arbiter: the favoured requester gets the grant unless it is idle while the
    // other one is valid, so exactly one requester sees ready in a slot.
    assign prefer1      = !i_prio_fixed && !rr_last1;
    assign gnt1         = prefer1 ? (i_req1_valid || !i_req0_valid)
                                  : (i_req1_valid && !i_req0_valid);
    assign o_req0_ready = slot && !gnt1;
    assign o_req1_ready = slot && gnt1;

    assign xfer0     = o_req0_ready && i_req0_valid;
    assign xfer1     = o_req1_ready && i_req1_valid;
    assign xfer      = xfer0 || xfer1;
    assign underflow = slot && (state == ST_RUN) && !i_req0_valid && !i_req1_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt; no latch.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (i_enable)  state_nxt = ST_ARMED;
            ST_ARMED: if (!i_enable) state_nxt = ST_IDLE;
                      else if (xfer) state_nxt = ST_RUN;
            ST_RUN:   if (!i_enable) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign o_state = state;

    // DAC register, strobe, grant and round-robin pointer, all updated on transfer.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            o_dac_data   <= DAC_RST_VAL;
            o_dac_strobe <= 1'b0;
            o_grant      <= 2'b00;
            rr_last1     <= 1'b1;
        end else begin
            o_dac_strobe <= xfer;
            if (xfer) begin
                o_dac_data <= to_dac(xfer1 ? i_req1_data : i_req0_data);
                o_grant    <= {xfer1, xfer0};
                rr_last1   <= xfer1;
            end
        end
    end

    // Saturating underflow counter; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            o_underflow_cnt <= 16'h0000;
        end else if (i_clr_underflow) begin
            o_underflow_cnt <= 16'h0000;
        end else if (underflow && o_underflow_cnt != 16'hFFFF) begin
            o_underflow_cnt <= o_underflow_cnt + 16'h0001;
        end
    end

endmodule

// File: doc/dac_feed_ctrl.md
DAC_FEED_CTRL -- requirements
Module: dac_feed_ctrl

Interface
REQ-001 Parameter DATA_W, default 14, DAC sample width.
REQ-002 Parameter DIV_W, default 16, sample-rate divider width.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_enable  input  1  level; 1 = feed DAC, 0 = idle.
REQ-006 i_rate_div  input  DIV_W  sample period minus one, in clk cycles.
REQ-007 i_prio_fixed  input  1  1 = requester 0 fixed priority; 0 = round-robin.
REQ-008 i_clr_underflow  input  1  single-cycle pulse, clears underflow counter.
REQ-009 i_req0_valid / i_req1_valid  input  1 each  sample offered.
REQ-010 i_req0_data / i_req1_data  input  DATA_W each  offered sample.
REQ-011 o_req0_ready / o_req1_ready  output  1 each  sample accepted this cycle when valid.
REQ-012 o_dac_data  output  DATA_W  registered sample to DAC data register.
REQ-013 o_dac_strobe  output  1  one-cycle pulse, o_dac_data updated this cycle.
REQ-014 o_grant  output  2  registered one-hot, requester of last transfer.
REQ-015 o_underflow_cnt  output  16  saturating count of missed sample slots.
REQ-016 o_state  output  2  current state: 0 IDLE, 1 ARMED, 2 RUN.

Function
REQ-017 Divider counts 0..i_rate_div; tick asserted in the cycle the count equals i_rate_div, then the count wraps to 0; i_rate_div=0 gives a tick every cycle.
REQ-018 i_rate_div is sampled only at wrap; mid-period changes take effect next period.
REQ-019 Divider is held at 0 with no ticks while in IDLE.
REQ-020 States: IDLE -> ARMED when i_enable=1; ARMED -> RUN on first transfer; ARMED or RUN -> IDLE in the cycle after i_enable=0.
REQ-021 Ready is asserted only in tick cycles in ARMED or RUN, to at most one requester (the grant); ready never depends on its own valid.
REQ-022 Fixed priority: requester 0 is granted whenever it is valid.
REQ-023 Round-robin: when both are valid, grant the requester not granted in the last transfer; the pointer updates only on a transfer.
REQ-024 Transfer (valid&&ready) in cycle N: o_dac_data = data and o_dac_strobe = 1 in cycle N+1; o_grant updated in N+1.
REQ-025 Tick in RUN with no valid requester: underflow; o_dac_data holds; o_dac_strobe=0; counter +1, saturating at 0xFFFF.
REQ-026 Ticks in ARMED without a transfer are not underflows.
REQ-027 i_clr_underflow wins over a simultaneous increment; the counter reads 0 next cycle.
REQ-028 Entering IDLE holds o_dac_data, o_grant and o_underflow_cnt; ready is deasserted in that same cycle.

Reset
REQ-029 Asynchronous assertion and synchronous release; during reset: state IDLE, divider 0, o_dac_data 0, o_dac_strobe 0, o_grant 0, o_underflow_cnt 0, round-robin pointer = requester 1 (so requester 0 wins the first tie).
REQ-030 Reset mid-transfer discards the in-flight sample; no strobe follows reset release.

Configuration
REQ-031 Macro DAC_FEED_OFFSET_BIN_EN: when defined, accepted samples are two's complement and o_dac_data = sample with MSB inverted (offset binary); reset value of o_dac_data is then 0x2000 for DATA_W=14.
REQ-032 Without DAC_FEED_OFFSET_BIN_EN, samples pass unmodified and the reset value of o_dac_data is 0.

Verification
REQ-033 i_rate_div=3, enable, req0 always valid with data 0x0123 -> strobe every 4 cycles, o_dac_data=0x0123 one cycle after each ready, o_underflow_cnt=0.
REQ-034 Round-robin, both valid, data 0x1111/0x2222, i_rate_div=0 -> outputs alternate 0x1111,0x2222,...; o_grant alternates 01,10.
REQ-035 Fixed priority, both valid -> req1 never ready; all samples 0x1111.
REQ-036 RUN, valids dropped for 5 ticks -> o_underflow_cnt=5, o_dac_data holds; clear pulse coincident with 6th underflow -> reads 0.
REQ-037 Force counter to 0xFFFE, 3 underflows -> saturates at 0xFFFF.
REQ-038 With DAC_FEED_OFFSET_BIN_EN, sample 0x3FFF (-1) -> o_dac_data=0x1FFF; reset asserted mid-period -> o_dac_data=0x2000, state IDLE, no strobe after release.
